calc_key_sequencer: RTL and testbench
=====================================

Name: calc_key_sequencer

Overview:
Top-level controller for the calculator. Consumes decoded keypad events, assembles operand A and operand B as BCD digits, and latches the operator (+/-). It launches the shared BCD add/sub ALU through a start/done handshake, then holds the result for the 7-segment display. It supports result chaining, clear, and an ALU watchdog.

Parameters:
NDIG, 4, number of BCD digits per operand/result
TIMEOUT, 16, max cycles from alu_start to alu_done before error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key_valid  in  1  one-cycle pulse; key_code valid this cycle
key_code  in  4  0-9 digit, 10 '+', 11 '-', 12 clear, 15 '='; 13/14 ignored
alu_done  in  1  one-cycle pulse; alu_result/alu_neg/alu_ovf valid
alu_result  in  4*NDIG  BCD magnitude
alu_neg  in  1  result negative
alu_ovf  in  1  result exceeds NDIG digits
alu_start  out  1  one-cycle launch pulse
alu_sub  out  1  0 add, 1 subtract; stable from start until done
alu_a  out  4*NDIG  operand A, BCD; stable from start until done
alu_b  out  4*NDIG  operand B, BCD; stable from start until done
disp_bcd  out  4*NDIG  value to display
disp_neg  out  1  minus sign
busy  out  1  high in WAIT_ALU
error  out  1  high in ERROR

Behaviour:
- Reset: state ENTER_A; A=B=0; digit counters=0; alu_sub=0; alu_start=0; disp_bcd=0; disp_neg=0; busy=0; error=0; watchdog=0. Reset mid-operation aborts everything. A later alu_done is ignored.
- States: ENTER_A, ENTER_B, WAIT_ALU, SHOW_RESULT, ERROR. All outputs are registered. A key at cycle n takes effect at n+1.
- Digit entry, shared by both operands:
  - Value = value*10 + d, done as a BCD left shift by one digit.
  - Digit counter increments only when the value becomes nonzero or is already nonzero. Leading zeros do not count.
  - When the counter reaches NDIG, further digits are ignored with no change.
- ENTER_A:
  - digit: shift into A.
  - '+'/'-': latch alu_sub, go to ENTER_B with B=0 and counter cleared.
  - '=': ignored.
  - disp_bcd=A, disp_neg=0.
- ENTER_B:
  - digit: shift into B.
  - '+'/'-': replaces the operator only while the B counter is 0; otherwise ignored.
  - '=': go to WAIT_ALU. B=0 is legal if no digits were entered.
  - disp_bcd shows B once the B counter is nonzero or any B digit has been entered; otherwise it shows A.
- WAIT_ALU:
  - alu_start=1 in the first cycle only.
  - All keys except clear are ignored.
  - Watchdog counts cycles after alu_start. Reaching TIMEOUT without alu_done goes to ERROR.
  - On alu_done with alu_ovf=1: go to ERROR.
  - On alu_done otherwise: go to SHOW_RESULT next cycle, with disp_bcd=alu_result and disp_neg=alu_neg.
  - If alu_done and the TIMEOUT boundary occur in the same cycle, alu_done wins.
- SHOW_RESULT:
  - '+'/'-': chain. A=alu_result magnitude, B=0, go to ENTER_B.
  - Chaining a negative result is refused: ignore the key and stay.
  - digit: A=0, the digit is shifted in, go to ENTER_A.
  - '=': ignored; no repeat-operation.
- ERROR: disp_bcd=0, error=1. Only clear exits.
- Clear (12) from any state: next cycle ENTER_A with all registers at reset values. In WAIT_ALU, clear aborts and the pending alu_done is discarded.
- key_valid and alu_done in the same cycle: only possible in WAIT_ALU; alu_done is processed and the key is dropped unless it is clear. Clear wins.
- key_valid must be a single-cycle pulse; the block does no debouncing.

Decomposition:
- Shared package calc_pkg holds:
  - key codes KEY_PLUS=10, KEY_MINUS=11, KEY_CLR=12, KEY_EQ=15;
  - the state enum;
  - NDIG default.
- One sub-module: bcd_digit_shift. It is combinational: current value, counter, digit in → next value, next counter, full. It is instantiated once and muxed between A and B.

Test Plan:
- reset; keys 1,2,'+',3,4,'=' with alu_done after 3 cycles returning 0046 → exactly one alu_start; alu_a=0012, alu_b=0034, alu_sub=0; disp_bcd=0046 one cycle after done.
- keys 5,'-',9,'=' with alu returning 0004, neg=1 → alu_sub=1; disp=0004, disp_neg=1; then '+' → ignored, state stays SHOW_RESULT.
- keys 0,0,7,8,9,1,2 (NDIG=4) → A=7891, the trailing 2 is ignored; then clear → disp=0 and all state reset.
- result 0046 shown, then '+',4,'=' → alu_a=0046, alu_b=0004; alu_done 0050 → disp=0050.
- '=' issued, alu_done never asserted → error=1 at start+TIMEOUT; digits ignored; clear → ENTER_A, error=0.
- '=' issued, clear during WAIT_ALU, alu_done arrives 2 cycles later → ignored, disp remains 0; alu_ovf=1 on a fresh run → ERROR.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer.
// Holds the keypad codes, the controller state encoding and the default
// operand width in BCD digits.
package calc_pkg;

    localparam int unsigned NDIG_DEF = 4;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_CLR   = 4'd12;
    localparam logic [3:0] KEY_EQ    = 4'd15;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_WAIT_ALU,
        ST_SHOW_RESULT,
        ST_ERROR
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_shift.sv
// Combinational BCD digit-entry step: value*10 + digit as a one-digit left shift.
// Ports:
//   value_in  current BCD value        cnt_in  significant digits entered so far
//   digit     new BCD digit            value_out/cnt_out  updated value/count
//   full      value already holds NDIG significant digits (digit is dropped)
module bcd_digit_shift
    import calc_pkg::*;
#(
    parameter int unsigned NDIG = NDIG_DEF,
    parameter int unsigned CW   = $clog2(NDIG + 1)
) (
    input  logic [4*NDIG-1:0] value_in,
    input  logic [CW-1:0]     cnt_in,
    input  logic [3:0]        digit,
    output logic [4*NDIG-1:0] value_out,
    output logic [CW-1:0]     cnt_out,
    output logic              full
);

    always_comb begin
        full      = (cnt_in == CW'(NDIG));
        value_out = value_in;
        cnt_out   = cnt_in;
        if (!full) begin
            value_out = {value_in[4*NDIG-5:0], digit};
            // Leading zeros leave the value at zero and are not counted.
            if (value_out != '0) begin
                cnt_out = cnt_in + CW'(1);
            end
        end
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator top-level controller.
// Assembles BCD operands A and B from keypad events, latches +/-, launches the
// shared BCD ALU via alu_start/alu_done and holds the result for the display.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   key_valid, key_code           decoded keypad event (single-cycle pulse)
//   alu_done, alu_result,
//   alu_neg, alu_ovf              ALU completion and result
//   alu_start, alu_sub,
//   alu_a, alu_b                  ALU launch pulse and operands
//   disp_bcd, disp_neg            display value and sign
//   busy, error                   waiting on ALU / error state
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned NDIG    = NDIG_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              alu_done,
    input  logic [4*NDIG-1:0] alu_result,
    input  logic              alu_neg,
    input  logic              alu_ovf,
    output logic              alu_start,
    output logic              alu_sub,
    output logic [4*NDIG-1:0] alu_a,
    output logic [4*NDIG-1:0] alu_b,
    output logic [4*NDIG-1:0] disp_bcd,
    output logic              disp_neg,
    output logic              busy,
    output logic              error
);

    localparam int unsigned CW = $clog2(NDIG + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [4*NDIG-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
    logic [CW-1:0]     a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic              b_seen_q, b_seen_d;
    logic              sub_q, sub_d, start_q, start_d;
    logic              neg_q, neg_d, busy_q, busy_d, err_q, err_d;
    logic [WW-1:0]     wd_q, wd_d;

    logic [4*NDIG-1:0] sh_in, sh_out;
    logic [CW-1:0]     sh_cnt_in, sh_cnt_out;
    logic              sh_full;
    logic              key_dig, key_op, key_eq, key_clr;

    assign key_dig = key_valid && is_digit(key_code);
    assign key_op  = key_valid && (key_code == KEY_PLUS || key_code == KEY_MINUS);
    assign key_eq  = key_valid && (key_code == KEY_EQ);
    assign key_clr = key_valid && (key_code == KEY_CLR);

    // One shifter serves both operands; a digit after a result starts A from zero.
    always_comb begin
        sh_in     = a_q;
        sh_cnt_in = a_cnt_q;
        if (state_q == ST_ENTER_B) begin
            sh_in     = b_q;
            sh_cnt_in = b_cnt_q;
        end else if (state_q == ST_SHOW_RESULT) begin
            sh_in     = '0;
            sh_cnt_in = '0;
        end
    end

    bcd_digit_shift #(
        .NDIG (NDIG),
        .CW   (CW)
    ) u_shift (
        .value_in  (sh_in),
        .cnt_in    (sh_cnt_in),
        .digit     (key_code),
        .value_out (sh_out),
        .cnt_out   (sh_cnt_out),
        .full      (sh_full)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        a_cnt_d  = a_cnt_q;
        b_cnt_d  = b_cnt_q;
        b_seen_d = b_seen_q;
        sub_d    = sub_q;
        start_d  = 1'b0;
        disp_d   = disp_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        err_d    = err_q;
        wd_d     = wd_q;

        unique case (state_q)
            ST_ENTER_A: begin
                if (key_dig) begin
                    a_d     = sh_out;
                    a_cnt_d = sh_cnt_out;
                    disp_d  = sh_out;
                end else if (key_op) begin
                    sub_d    = (key_code == KEY_MINUS);
                    b_d      = '0;
                    b_cnt_d  = '0;
                    b_seen_d = 1'b0;
                    state_d  = ST_ENTER_B;
                end
            end
            ST_ENTER_B: begin
                if (key_dig) begin
                    b_d      = sh_out;
                    b_cnt_d  = sh_cnt_out;
                    b_seen_d = 1'b1;
                    disp_d   = sh_out;
                end else if (key_op) begin
                    if (b_cnt_q == '0) begin
                        sub_d = (key_code == KEY_MINUS);
                    end
                end else if (key_eq) begin
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    wd_d    = '0;
                    state_d = ST_WAIT_ALU;
                end
            end
            ST_WAIT_ALU: begin
                // alu_done takes precedence over the watchdog boundary.
                if (alu_done) begin
                    busy_d = 1'b0;
                    if (alu_ovf) begin
                        err_d   = 1'b1;
                        disp_d  = '0;
                        neg_d   = 1'b0;
                        state_d = ST_ERROR;
                    end else begin
                        disp_d  = alu_result;
                        neg_d   = alu_neg;
                        state_d = ST_SHOW_RESULT;
                    end
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    disp_d  = '0;
                    neg_d   = 1'b0;
                    state_d = ST_ERROR;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            ST_SHOW_RESULT: begin
                if (key_op) begin
                    if (!neg_q) begin
                        a_d      = disp_q;
                        a_cnt_d  = '0;
                        sub_d    = (key_code == KEY_MINUS);
                        b_d      = '0;
                        b_cnt_d  = '0;
                        b_seen_d = 1'b0;
                        state_d  = ST_ENTER_B;
                    end
                end else if (key_dig) begin
                    a_d     = sh_out;
                    a_cnt_d = sh_cnt_out;
                    disp_d  = sh_out;
                    neg_d   = 1'b0;
                    state_d = ST_ENTER_A;
                end
            end
            ST_ERROR: begin
            end
            default: state_d = ST_ENTER_A;
        endcase

        if (key_clr) begin
            state_d  = ST_ENTER_A;
            a_d      = '0;
            b_d      = '0;
            a_cnt_d  = '0;
            b_cnt_d  = '0;
            b_seen_d = 1'b0;
            sub_d    = 1'b0;
            start_d  = 1'b0;
            disp_d   = '0;
            neg_d    = 1'b0;
            busy_d   = 1'b0;
            err_d    = 1'b0;
            wd_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_ENTER_A;
            a_q      <= '0;
            b_q      <= '0;
            a_cnt_q  <= '0;
            b_cnt_q  <= '0;
            b_seen_q <= 1'b0;
            sub_q    <= 1'b0;
            start_q  <= 1'b0;
            disp_q   <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_cnt_q  <= a_cnt_d;
            b_cnt_q  <= b_cnt_d;
            b_seen_q <= b_seen_d;
            sub_q    <= sub_d;
            start_q  <= start_d;
            disp_q   <= disp_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    assign alu_start = start_q;
    assign alu_sub   = sub_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign disp_bcd  = disp_q;
    assign disp_neg  = neg_q;
    assign busy      = busy_q;
    assign error     = err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
module tb_calc_key_sequencer;

    localparam int unsigned NDIG    = 4;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              key_valid;
    logic [3:0]        key_code;
    logic              alu_done;
    logic [4*NDIG-1:0] alu_result;
    logic              alu_neg;
    logic              alu_ovf;
    logic              alu_start;
    logic              alu_sub;
    logic [4*NDIG-1:0] alu_a;
    logic [4*NDIG-1:0] alu_b;
    logic [4*NDIG-1:0] disp_bcd;
    logic              disp_neg;
    logic              busy;
    logic              error;

    calc_key_sequencer #(
        .NDIG    (NDIG),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_neg    (alu_neg),
        .alu_ovf    (alu_ovf),
        .alu_start  (alu_start),
        .alu_sub    (alu_sub),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .disp_bcd   (disp_bcd),
        .disp_neg   (disp_neg),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int starts = 0;

    always @(posedge clk) begin
        if (alu_start === 1'b1) starts <= starts + 1;
    end

    typedef struct {
        logic [3:0]  key;
        logic [15:0] disp;
        logic        sub;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic pulse_done(input logic [15:0] r, input logic n, input logic o);
        alu_done   = 1'b1;
        alu_result = r;
        alu_neg    = n;
        alu_ovf    = o;
        step();
        alu_done   = 1'b0;
        alu_result = '0;
        alu_neg    = 1'b0;
        alu_ovf    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int snap;

        vecs[0]  = '{4'd0,  16'h0000, 1'b0};
        vecs[1]  = '{4'd0,  16'h0000, 1'b0};
        vecs[2]  = '{4'd7,  16'h0007, 1'b0};
        vecs[3]  = '{4'd8,  16'h0078, 1'b0};
        vecs[4]  = '{4'd9,  16'h0789, 1'b0};
        vecs[5]  = '{4'd1,  16'h7891, 1'b0};
        vecs[6]  = '{4'd2,  16'h7891, 1'b0};
        vecs[7]  = '{4'd13, 16'h7891, 1'b0};
        vecs[8]  = '{4'd15, 16'h7891, 1'b0};
        vecs[9]  = '{4'd11, 16'h7891, 1'b1};
        vecs[10] = '{4'd10, 16'h7891, 1'b0};
        vecs[11] = '{4'd0,  16'h0000, 1'b0};
        vecs[12] = '{4'd5,  16'h0005, 1'b0};
        vecs[13] = '{4'd11, 16'h0005, 1'b0};
        vecs[14] = '{4'd12, 16'h0000, 1'b0};
        vecs[15] = '{4'd3,  16'h0003, 1'b0};

        reset = 1'b1; key_valid = 1'b0; key_code = 4'd0;
        alu_done = 1'b0; alu_result = '0; alu_neg = 1'b0; alu_ovf = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_disp", disp_bcd, 0);
        chk("rst_neg", disp_neg, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_sub", alu_sub, 0);
        chk("rst_ab", {alu_a, alu_b}, 0);

        for (int i = 0; i < 16; i++) begin
            press(vecs[i].key);
            chk($sformatf("vec%0d_disp", i), disp_bcd, vecs[i].disp);
            chk($sformatf("vec%0d_sub", i), alu_sub, vecs[i].sub);
            chk($sformatf("vec%0d_flags", i), {busy, error, disp_neg}, 0);
        end

        // 12 + 34
        press(4'd12);
        press(4'd1); press(4'd2); press(4'd10); press(4'd3); press(4'd4);
        snap = starts;
        press(4'd15);
        chk("add_start", alu_start, 1);
        chk("add_busy", busy, 1);
        chk("add_a", alu_a, 16'h0012);
        chk("add_b", alu_b, 16'h0034);
        chk("add_sub", alu_sub, 0);
        step();
        chk("add_start_once", alu_start, 0);
        chk("add_a_hold", alu_a, 16'h0012);
        step();
        pulse_done(16'h0046, 1'b0, 1'b0);
        chk("add_disp", disp_bcd, 16'h0046);
        chk("add_flags", {busy, error, disp_neg}, 0);
        chk("add_start_count", starts - snap, 1);

        // chain: 46 + 4
        press(4'd10);
        chk("chain_disp_a", disp_bcd, 16'h0046);
        press(4'd4);
        chk("chain_disp_b", disp_bcd, 16'h0004);
        press(4'd15);
        chk("chain_a", alu_a, 16'h0046);
        chk("chain_b", alu_b, 16'h0004);
        step();
        pulse_done(16'h0050, 1'b0, 1'b0);
        chk("chain_disp", disp_bcd, 16'h0050);

        // 5 - 9, negative result refuses chaining
        press(4'd5);
        chk("sub_disp_a", disp_bcd, 16'h0005);
        press(4'd11); press(4'd9); press(4'd15);
        chk("sub_sub", alu_sub, 1);
        step();
        pulse_done(16'h0004, 1'b1, 1'b0);
        chk("sub_disp", {disp_neg, disp_bcd}, {1'b1, 16'h0004});
        press(4'd10);
        chk("negchain_refused", {disp_neg, disp_bcd, busy}, {1'b1, 16'h0004, 1'b0});
        press(4'd15);
        chk("eq_no_repeat", {disp_neg, disp_bcd, busy, alu_start}, {1'b1, 16'h0004, 2'b00});
        press(4'd3);
        chk("digit_after_result", {disp_neg, disp_bcd}, {1'b0, 16'h0003});

        // watchdog timeout
        press(4'd12);
        press(4'd1); press(4'd10); press(4'd2); press(4'd15);
        repeat (TIMEOUT - 1) step();
        chk("wd_before", {busy, error}, 2'b10);
        step();
        chk("wd_error", {busy, error}, 2'b01);
        chk("wd_disp", disp_bcd, 0);
        press(4'd5);
        chk("err_digit_ignored", {error, disp_bcd}, {1'b1, 16'h0000});
        press(4'd12);
        chk("err_clear", {busy, error, disp_bcd}, 0);

        // alu_done on the watchdog boundary wins
        press(4'd2); press(4'd10); press(4'd3); press(4'd15);
        repeat (TIMEOUT - 1) step();
        pulse_done(16'h0005, 1'b0, 1'b0);
        chk("boundary_done", {error, busy, disp_bcd}, {2'b00, 16'h0005});

        // clear aborts WAIT_ALU; late alu_done discarded
        press(4'd12);
        press(4'd1); press(4'd10); press(4'd2); press(4'd15);
        press(4'd12);
        chk("abort_clear", {busy, error, disp_bcd}, 0);
        step(); step();
        pulse_done(16'h0099, 1'b0, 1'b0);
        chk("late_done_ignored", {busy, error, disp_neg, disp_bcd}, 0);
        press(4'd8);
        chk("after_abort_enter", disp_bcd, 16'h0008);

        // overflow
        press(4'd10); press(4'd9); press(4'd15);
        step();
        pulse_done(16'h0000, 1'b0, 1'b1);
        chk("ovf_error", {busy, error, disp_bcd}, {2'b01, 16'h0000});
        press(4'd12);
        chk("ovf_clear", {busy, error, disp_bcd}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
